// File: rtl/reg_file_sb_pkg.sv
// Shared types and default sizes for the reg_file_sb register file with busy scoreboard.
package reg_file_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit vector: one pending flag per register, set wins over clear, bit 0 never busy.
module reg_file_sb_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  // Set is applied after clear so a same-address issue leaves the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with busy scoreboard and a sequential clear sweep after reset / on request.
// Optional write-to-read bypass enabled by defining REG_FILE_SB_BYPASS_EN.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WR_EN,
  input  logic [AW-1:0]   WR_ADDR,
  input  logic [XLEN-1:0] WR_DATA,
  input  logic [AW-1:0]   RD_ADDR1,
  input  logic [AW-1:0]   RD_ADDR2,
  output logic [XLEN-1:0] RS1,
  output logic [XLEN-1:0] RS2,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_ADDR,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            CLR_START,
  output logic            CLR_BUSY
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_e          state_d, state_q;
  logic [AW-1:0]   cnt_d, cnt_q;
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic            idle, wr_ok, iss_ok;
  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rs [2];
  logic            busy [2];

  assign idle   = (state_q == IDLE);
  assign wr_ok  = idle && WR_EN && (WR_ADDR != '0);
  assign iss_ok = idle && ISSUE_EN && (ISSUE_ADDR != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST) state_d = IDLE;
        else               cnt_d   = cnt_q + AW'(1);
      end
      IDLE: begin
        if (CLR_START) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data is never reset; the sweep zeroes one entry per cycle instead.
  always_comb begin
    regs_d = regs_q;
    if (!idle)      regs_d[cnt_q]   = '0;
    else if (wr_ok) regs_d[WR_ADDR] = WR_DATA;
  end

  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  reg_file_sb_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (CLK),
    .rst      (RST),
    .set_en   (iss_ok),
    .set_addr (ISSUE_ADDR),
    .clr_en   (wr_ok || !idle),
    .clr_addr (idle ? WR_ADDR : cnt_q),
    .busy_vec (busy_vec)
  );

  assign rd_addr[0] = RD_ADDR1;
  assign rd_addr[1] = RD_ADDR2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs[p]   = '0;
      busy[p] = 1'b0;
      if (idle && rd_addr[p] != '0) begin
        rs[p]   = regs_q[rd_addr[p]];
        busy[p] = busy_vec[rd_addr[p]];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_ok && WR_ADDR == rd_addr[p]) begin
          rs[p]   = WR_DATA;
          busy[p] = iss_ok && (ISSUE_ADDR == rd_addr[p]);
        end
`endif
      end
    end
  end

  assign RS1      = rs[0];
  assign RS2      = rs[1];
  assign BUSY1    = busy[0];
  assign BUSY2    = busy[1];
  assign CLR_BUSY = (state_q == CLEAR);

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width of every register and data port.
REQ-002 Parameter NREGS, default 32, SHALL set the register count; it SHALL be a power of two, at least 2.
REQ-003 Localparam AW = $clog2(NREGS) SHALL set the width of every address port.
REQ-004 CLK  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 WR_EN  input  1  SHALL be the write strobe.
REQ-007 WR_ADDR / WR_DATA  input  AW / XLEN  SHALL be the write address and write data.
REQ-008 RD_ADDR1 / RD_ADDR2  input  AW each  SHALL be the read addresses.
REQ-009 RS1 / RS2  output  XLEN each  SHALL be the combinational read data.
REQ-010 ISSUE_EN / ISSUE_ADDR  input  1 / AW  SHALL mark a destination register as pending.
REQ-011 BUSY1 / BUSY2  output  1 each  SHALL flag that RD_ADDR1 / RD_ADDR2 is pending.
REQ-012 CLR_START  input  1  SHALL request a full sequential clear.
REQ-013 CLR_BUSY  output  1  SHALL be high while a clear is in progress.

Function
REQ-014 Register 0 SHALL always read 0, SHALL never be written and SHALL never be busy.
REQ-015 The FSM SHALL have two states: CLEAR and IDLE.
- CLEAR: clears one register per cycle at index CNT, and CNT increments.
- CLEAR -> IDLE occurs on the cycle after CNT = NREGS-1 is cleared.
- IDLE -> CLEAR occurs on CLR_START, with CNT reset to 0.
REQ-016 A clear SHALL take exactly NREGS cycles; CLR_BUSY SHALL equal (state == CLEAR).
REQ-017 In CLEAR, the block SHALL ignore WR_EN, ISSUE_EN and CLR_START; RS1/RS2 SHALL read 0 and BUSY1/BUSY2 SHALL read 0.
REQ-018 In IDLE, WR_EN=1 with WR_ADDR!=0 SHALL write WR_DATA at the next rising edge and clear the busy bit of WR_ADDR.
REQ-019 In IDLE, ISSUE_EN=1 with ISSUE_ADDR!=0 SHALL set the busy bit of ISSUE_ADDR at the next rising edge.
REQ-020 If ISSUE and write target the same address in the same cycle, the data SHALL be written and the busy bit SHALL end set (issue wins).
REQ-021 Reads SHALL have zero-cycle latency; without bypass (see REQ-026), reads SHALL return pre-edge contents.
REQ-022 The clear counter SHALL be AW bits wide, with terminal detection at NREGS-1 and no wrap-around.

Reset
REQ-023 RST SHALL asynchronously force state=CLEAR, CNT=0 and all busy bits to 0.
REQ-024 Register contents SHALL NOT be reset directly; they are cleared by the CLEAR sweep, so RS1/RS2 = 0 and CLR_BUSY = 1 immediately after reset.
REQ-025 RST asserted mid-clear or mid-operation SHALL restart the sweep from CNT=0.

Configuration
REQ-026 With macro REG_FILE_SB_BYPASS_EN defined, in IDLE a read address equal to a same-cycle WR_ADDR (WR_EN=1, nonzero) SHALL return WR_DATA.
- In that same case, the matching BUSY output SHALL read 0 unless a same-cycle ISSUE also targets that address.
REQ-027 Without REG_FILE_SB_BYPASS_EN, reads SHALL return stored contents only, and BUSY SHALL reflect only registered busy bits.

Structure
REQ-028 A shared package reg_file_sb_pkg SHALL hold the FSM state enum (CLEAR, IDLE) and the default XLEN/NREGS constants.
REQ-029 A sub-module reg_file_sb_scoreboard SHALL implement the NREGS-bit busy vector with its set/clear/priority logic.

Verification
REQ-030 Reset, then observe: CLR_BUSY=1 for exactly 32 cycles, then 0; RS1 at any address = 0.
REQ-031 Write x5=0xDEADBEEF in IDLE, then RD_ADDR1=5 next cycle -> RS1=0xDEADBEEF; a write to x0 of 0x1 -> RS1 at x0 = 0.
REQ-032 ISSUE x7, then RD_ADDR2=7 -> BUSY2=1; write x7=0x55 -> BUSY2=0 next cycle; simultaneous ISSUE and write to x7 -> BUSY2=1 and RS2=0x55.
REQ-033 With the bypass macro: write x3=0x1234 while RD_ADDR1=3 -> RS1=0x1234 in the same cycle; without the macro -> RS1 shows the old value.
REQ-034 After writing x9=0xA, pulse CLR_START; WR_EN during the sweep is ignored; afterwards x9=0 and no register is busy.
REQ-035 Assert RST at sweep cycle 10 -> CNT restarts, and CLR_BUSY stays high for 32 more cycles after release.
